// File: rtl/bus_ram_pkg.sv
// rtl/bus_ram_pkg.sv - shared state encoding and address-phase helper for bus_ram_burst
package bus_ram_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ADDR  = 2'd1,
    STATE_WRITE = 2'd2,
    STATE_READ  = 2'd3
  } state_e;

  // Number of bus beats needed to carry one address.
  function automatic int addr_phases(input int addr_w, input int data_w);
    return (addr_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/tri_buf.sv
// rtl/tri_buf.sv - bidirectional bus buffer, drives the pad only while rw is high
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rw,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus    = rw ? data_i : {WIDTH{1'bz}};
  assign data_o = bus;

endmodule

// File: rtl/bus_ram_burst.sv
// rtl/bus_ram_burst.sv - RAM on a shared tri-state bus; define BUS_RAM_BURST_EN for burst mode
module bus_ram_burst
  import bus_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              rw,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy
);

  localparam int ADDR_PHASES = addr_phases(ADDR_W, DATA_W);
  localparam int FULL_W      = ADDR_PHASES * DATA_W;
  localparam int BEAT_W      = (ADDR_PHASES > 1) ? $clog2(ADDR_PHASES) : 1;
  localparam int DEPTH       = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [FULL_W-1:0] addr_full_q, addr_full_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rw_q, rw_d;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              bus_oe;
  logic              mem_we;

  // Address bits above ADDR_W in the last beat are captured but never used.
  assign addr     = addr_full_q[ADDR_W-1:0];
  assign addr_inc = addr + 1'b1;
  assign bus_oe   = (state_q == STATE_READ);
  assign rd_data  = mem[addr];
  assign mem_we   = (state_q == STATE_WRITE) && enable && !reset;
  assign busy     = busy_q;

  tri_buf #(
    .WIDTH (DATA_W)
  ) u_tri_buf (
    .rw     (bus_oe),
    .data_i (rd_data),
    .data_o (bus_in),
    .bus    (bus)
  );

  // Next-state logic: address beats, data beats and aborts on enable low.
  always_comb begin
    state_d     = state_q;
    addr_full_d = addr_full_q;
    beat_d      = beat_q;
    rw_d        = rw_q;
    unique case (state_q)
      STATE_IDLE: begin
        if (enable) begin
          addr_full_d               = '0;
          addr_full_d[DATA_W-1:0]   = bus_in;
          rw_d                      = rw;
          beat_d                    = BEAT_W'(1);
          if (ADDR_PHASES > 1) state_d = STATE_ADDR;
          else                 state_d = rw ? STATE_WRITE : STATE_READ;
        end
      end
      STATE_ADDR: begin
        if (!enable) begin
          state_d = STATE_IDLE;
        end else begin
          for (int p = 1; p < ADDR_PHASES; p++) begin
            if (beat_q == BEAT_W'(p)) addr_full_d[p*DATA_W +: DATA_W] = bus_in;
          end
          if (beat_q == BEAT_W'(ADDR_PHASES - 1)) begin
            state_d = rw_q ? STATE_WRITE : STATE_READ;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      STATE_WRITE, STATE_READ: begin
`ifdef BUS_RAM_BURST_EN
        if (!enable) begin
          state_d = STATE_IDLE;
        end else begin
          addr_full_d             = '0;
          addr_full_d[ADDR_W-1:0] = addr_inc;
        end
`else
        state_d = STATE_IDLE;
`endif
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Control registers; reset wins over any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= STATE_IDLE;
      addr_full_q <= '0;
      beat_q      <= '0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_full_q <= addr_full_d;
      beat_q      <= beat_d;
      rw_q        <= rw_d;
      busy_q      <= (state_d != STATE_IDLE);
    end
  end

  // Memory array: written only on an enabled data beat, untouched by reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr] <= bus_in;
  end

endmodule

// File: doc/bus_ram_burst.md
BUS_RAM_BURST -- requirements
Module: bus_ram_burst

Interface
REQ-001 Parameter DATA_W, default 8, width of the shared bus and of each memory word.
REQ-002 Parameter ADDR_W, default 8, address width; depth is 2**ADDR_W words.
REQ-003 Localparam ADDR_PHASES = ceil(ADDR_W/DATA_W), the number of bus beats per address.
REQ-004 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port enable, input, 1, high selects the RAM; low for one rising edge ends or aborts any transaction.
REQ-007 Port rw, input, 1, 1 = write, 0 = read; sampled only on the first address beat.
REQ-008 Port bus, inout, DATA_W, shared tri-state bus carrying address beats, write data and read data.
REQ-009 Port busy, output, 1, high whenever state is not STATE_IDLE.

Function
REQ-010 The block SHALL implement states STATE_IDLE, STATE_ADDR, STATE_WRITE and STATE_READ.
REQ-011 In IDLE, at a rising edge with enable=1, the block SHALL capture bus into address bits [DATA_W-1:0] and latch rw.
REQ-012 After that edge it SHALL enter ADDR if ADDR_PHASES>1, otherwise WRITE (rw=1) or READ (rw=0).
REQ-013 In ADDR, each edge with enable=1 SHALL capture the next address beat, low beat first; after the last beat the block SHALL enter WRITE or READ.
REQ-014 Address bits beyond ADDR_W in the final beat SHALL be ignored.
REQ-015 In WRITE, an edge with enable=1 SHALL store bus into memory[addr].
REQ-016 In READ, the block SHALL drive memory[addr] onto bus for the whole cycle, starting the cycle after the last address beat.
REQ-017 The block SHALL drive bus only in READ; in every other state bus SHALL be high-impedance.
REQ-018 An edge with enable=0 in ADDR, WRITE or READ SHALL return the block to IDLE with no memory write.
REQ-019 rw changes after the first address beat SHALL be ignored until the block returns to IDLE.
REQ-020 A write SHALL have latency 1 + ADDR_PHASES edges from the first address beat; data SHALL be visible in memory after that edge.
REQ-021 Read data SHALL appear on bus ADDR_PHASES edges after the first address beat.

Reset
REQ-022 With reset=1 at a rising edge, the block SHALL enter IDLE, clear the address register and clear the latched rw.
REQ-023 After that edge, busy SHALL be 0 and bus SHALL be released.
REQ-024 Reset SHALL override enable, including mid-transaction; an in-flight write beat at the reset edge SHALL NOT be stored.
REQ-025 Memory contents SHALL NOT be altered by reset.

Configuration
REQ-026 Macro BUS_RAM_BURST_EN SHALL select burst behaviour at compile time.
REQ-027 With BUS_RAM_BURST_EN defined: after each data beat with enable=1, the state SHALL be unchanged and addr SHALL increment by 1, wrapping from 2**ADDR_W-1 to 0.
REQ-028 With BUS_RAM_BURST_EN defined, the address SHALL advance each READ cycle with enable=1, so consecutive words stream one per cycle.
REQ-029 Without BUS_RAM_BURST_EN: exactly one data beat SHALL occur per transaction, then the block SHALL return to IDLE regardless of enable.
REQ-030 Without BUS_RAM_BURST_EN, if enable is still 1 at the next edge, it SHALL be taken as a new first address beat.

Structure
REQ-031 Package bus_ram_pkg SHALL hold the state enum typedef (STATE_IDLE, STATE_ADDR, STATE_WRITE, STATE_READ) and the ADDR_PHASES helper function.
REQ-032 Bus driving SHALL use the existing tri_buf sub-module, with WIDTH=DATA_W and rw tied to (state==STATE_READ).

Verification (defaults DATA_W=8, ADDR_W=8 unless stated)
REQ-033 Single write/read: write 15 to addr 10, then read addr 10 -> memory[10]=15; bus=15 in the READ cycle; bus='z in IDLE afterwards.
REQ-034 Burst (macro on): write 0xA1,0xA2,0xA3 from addr 0xFE -> memory[0xFE]=0xA1, memory[0xFF]=0xA2, memory[0x00]=0xA3 (wrap); burst read from 0xFE returns the same three values on consecutive cycles.
REQ-035 Burst off: hold enable=1 through a 0x55 write to addr 3 -> only memory[3]=0x55; the next beat is taken as a new address with busy=1.
REQ-036 Abort: DATA_W=8, ADDR_W=12; send beat 0x34, drop enable -> IDLE, busy=0, no memory changes; full address 0x234 write 0x77 -> memory[0x234]=0x77.
REQ-037 Reset mid-READ: reset=1 while driving -> next edge busy=0, bus='z; memory unchanged.
REQ-038 rw toggled to 0 during a write's data beat -> write still performed and bus never driven.
